// File: rtl/vdf_sq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vdf_sq_sequencer
//  Purpose  : Iteration controller that feeds a pipelined modular squarer its
//             own results T times, with result timeout and abort draining.
//  Revision : 1.0
// ============================================================================
module vdf_sq_sequencer #(
   parameter int WORD_BITS       = 8,
   parameter int NUM_WORDS       = 4,
   parameter int REDUN_WORD_BITS = 1,
   parameter int I_WORD          = NUM_WORDS + 1,
   parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
   parameter int ITER_BITS       = 32,
   parameter int TIMEOUT         = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic [ITER_BITS-1:0]          i_iters,
   input  logic [I_WORD*COEF_BITS-1:0]   i_dat,
   input  logic                          i_abort,
   output logic                          o_busy,
   output logic                          o_sq_val,
   output logic [I_WORD*COEF_BITS-1:0]   o_sq_dat,
   input  logic                          i_sq_val,
   input  logic [I_WORD*COEF_BITS-1:0]   i_sq_dat,
   output logic                          o_val,
   output logic [I_WORD*COEF_BITS-1:0]   o_dat,
   input  logic                          i_rdy,
   output logic                          o_err,
   output logic [ITER_BITS-1:0]          o_iter_cnt
);

   localparam int DAT_BITS = I_WORD * COEF_BITS;
   localparam int TMO_BITS = $clog2(TIMEOUT);
   localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [DAT_BITS-1:0]    value, value_nxt, sq_dat_nxt;
   logic [ITER_BITS-1:0]   remaining, remaining_nxt, iter_cnt_nxt;
   logic [TMO_BITS-1:0]    tmo_cnt, tmo_cnt_nxt;
   logic                   sq_val_nxt, err_nxt;
   logic                   timed_out;

   assign timed_out = (tmo_cnt == TMO_LAST);
   assign o_dat     = value;

   always_comb begin
      state_nxt     = state;
      value_nxt     = value;
      remaining_nxt = remaining;
      iter_cnt_nxt  = o_iter_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      sq_val_nxt    = 1'b0;
      sq_dat_nxt    = o_sq_dat;
      err_nxt       = o_err;
      case (state)
         IDLE: begin
            if (i_start) begin
               value_nxt     = i_dat;
               remaining_nxt = i_iters;
               iter_cnt_nxt  = '0;
               err_nxt       = 1'b0;
               tmo_cnt_nxt   = '0;
               if (i_iters == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt  = WAIT;
                  sq_val_nxt = 1'b1;
                  sq_dat_nxt = i_dat;
               end
            end
         end
         WAIT: begin
            // Abort beats a coincident result; if the result or timeout is here
            // nothing is left in flight, so skip the drain.
            if (i_abort) begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
               if (i_sq_val || timed_out) state_nxt = IDLE;
               else                       state_nxt = DRAIN;
            end else if (i_sq_val) begin
               value_nxt     = i_sq_dat;
               iter_cnt_nxt  = o_iter_cnt + 1'b1;
               remaining_nxt = remaining - 1'b1;
               tmo_cnt_nxt   = '0;
               if (remaining == ITER_BITS'(1)) begin
                  state_nxt = DONE;
               end else begin
                  sq_val_nxt = 1'b1;
                  sq_dat_nxt = i_sq_dat;
               end
            end else if (timed_out) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (i_sq_val || timed_out) state_nxt = IDLE;
            else                       tmo_cnt_nxt = tmo_cnt + 1'b1;
         end
         DONE: begin
            if (i_abort || i_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         value      <= '0;
         remaining  <= '0;
         tmo_cnt    <= '0;
         o_busy     <= 1'b0;
         o_sq_val   <= 1'b0;
         o_sq_dat   <= '0;
         o_val      <= 1'b0;
         o_err      <= 1'b0;
         o_iter_cnt <= '0;
      end else begin
         state      <= state_nxt;
         value      <= value_nxt;
         remaining  <= remaining_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         o_busy     <= (state_nxt != IDLE);
         o_sq_val   <= sq_val_nxt;
         o_sq_dat   <= sq_dat_nxt;
         o_val      <= (state_nxt == DONE);
         o_err      <= err_nxt;
         o_iter_cnt <= iter_cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vdf_sq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vdf_sq_sequencer
//  Purpose  : Directed self-checking bench with a +1 squarer model.
//  Revision : 1.0
// ============================================================================
module tb_vdf_sq_sequencer;

   localparam int DW  = 45;
   localparam int IB  = 32;
   localparam int TMO = 16;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_start = 1'b0;
   logic [IB-1:0]  i_iters = '0;
   logic [DW-1:0]  i_dat = '0;
   logic           i_abort = 1'b0;
   logic           i_sq_val = 1'b0;
   logic [DW-1:0]  i_sq_dat = '0;
   logic           i_rdy = 1'b0;
   logic           o_busy, o_sq_val, o_val, o_err;
   logic [DW-1:0]  o_sq_dat, o_dat;
   logic [IB-1:0]  o_iter_cnt;

   vdf_sq_sequencer #(.TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_iters(i_iters),
      .i_dat(i_dat), .i_abort(i_abort), .o_busy(o_busy), .o_sq_val(o_sq_val),
      .o_sq_dat(o_sq_dat), .i_sq_val(i_sq_val), .i_sq_dat(i_sq_dat),
      .o_val(o_val), .o_dat(o_dat), .i_rdy(i_rdy), .o_err(o_err),
      .o_iter_cnt(o_iter_cnt)
   );

   always #5 i_clk = ~i_clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   // squarer model: result = operand + 1, sq_lat cycles after issue
   int            sq_lat    = 10;
   int            sq_drop   = 0;
   int            issue_cnt = 0;
   int            pend_cd   = 0;
   bit            pend      = 1'b0;
   bit            pend_drop = 1'b0;
   logic [DW-1:0] pend_dat  = '0;
   int            issue_cyc [16];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge i_clk);
      cyc++;
      i_sq_val = 1'b0;
      if (pend) begin
         pend_cd--;
         if (pend_cd == 0) begin
            pend = 1'b0;
            if (!pend_drop) begin
               i_sq_val = 1'b1;
               i_sq_dat = pend_dat;
            end
         end
      end
      if (o_sq_val) begin
         issue_cnt++;
         if (issue_cnt <= 16) issue_cyc[issue_cnt-1] = cyc;
         pend      = 1'b1;
         pend_cd   = sq_lat;
         pend_dat  = o_sq_dat + 1'b1;
         pend_drop = (issue_cnt == sq_drop);
      end
   endtask

   task automatic start_job(input logic [DW-1:0] d, input logic [IB-1:0] t, output int t0);
      i_dat   = d;
      i_iters = t;
      i_start = 1'b1;
      t0      = cyc;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_val(input int budget, output int at);
      int n = 0;
      while (!o_val && n < budget) begin
         tick();
         n++;
      end
      check_eq("wait_val", o_val, 1);
      at = cyc;
   endtask

   task automatic consume;
      i_rdy = 1'b1;
      tick();
      i_rdy = 1'b0;
      check_eq("val_drop", o_val, 0);
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_busy"},   o_busy, 0);
      check_eq({tag, "_sqval"},  o_sq_val, 0);
      check_eq({tag, "_val"},    o_val, 0);
      check_eq({tag, "_err"},    o_err, 0);
      check_eq({tag, "_dat"},    o_dat, 0);
      check_eq({tag, "_sqdat"},  o_sq_dat, 0);
      check_eq({tag, "_iter"},   o_iter_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, at, n;
      bit seen_val;
      repeat (3) tick();
      check_reset_outs("rst");
      i_rst = 1'b0;
      tick();

      // T = 0: result straight back in cycle 1, nothing issued
      issue_cnt = 0;
      start_job(45'h1234, 0, t0);
      check_eq("t0_val",    o_val, 1);
      check_eq("t0_dat",    o_dat, 45'h1234);
      check_eq("t0_iter",   o_iter_cnt, 0);
      check_eq("t0_sqval",  o_sq_val, 0);
      check_eq("t0_issues", issue_cnt, 0);
      consume();

      // T = 4, L = 10, start 5 -> 9 in cycle 45
      issue_cnt = 0;
      start_job(5, 4, t0);
      wait_val(200, at);
      check_eq("t4_lat",    at - t0, 45);
      check_eq("t4_issues", issue_cnt, 4);
      check_eq("t4_first",  issue_cyc[0] - t0, 1);
      for (int i = 1; i < 4; i++) check_eq("t4_gap", issue_cyc[i] - issue_cyc[i-1], 11);
      check_eq("t4_dat",  o_dat, 9);
      check_eq("t4_iter", o_iter_cnt, 4);
      check_eq("t4_err",  o_err, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("hold_val",  o_val, 1);
         check_eq("hold_dat",  o_dat, 9);
         check_eq("hold_iter", o_iter_cnt, 4);
         if (i == 2) begin
            i_sq_val = 1'b1;
            i_sq_dat = 45'h55;
         end
      end
      consume();
      i_sq_val = 1'b1;
      i_sq_dat = 45'h77;
      tick();
      check_eq("idle_spur_busy", o_busy, 0);
      check_eq("idle_spur_dat",  o_dat, 9);
      check_eq("idle_spur_iter", o_iter_cnt, 4);

      // second result dropped, T = 3 -> timeout after first capture
      issue_cnt = 0;
      sq_drop   = 2;
      start_job(5, 3, t0);
      wait_val(200, at);
      check_eq("tmo_lat",  at - t0, 28);
      check_eq("tmo_err",  o_err, 1);
      check_eq("tmo_iter", o_iter_cnt, 1);
      check_eq("tmo_dat",  o_dat, 6);
      consume();
      sq_drop = 0;

      // abort three cycles after the second issue, drain the stale result
      issue_cnt = 0;
      start_job(5, 3, t0);
      n = 0;
      while (issue_cnt < 2 && n < 100) begin
         tick();
         n++;
      end
      check_eq("abort_issue2", issue_cnt, 2);
      repeat (3) tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check_eq("drain_busy",  o_busy, 1);
      check_eq("drain_sqval", o_sq_val, 0);
      seen_val = o_val;
      n = 0;
      while (o_busy && n < 100) begin
         tick();
         n++;
         if (o_val) seen_val = 1'b1;
      end
      check_eq("drain_noval",  seen_val, 0);
      check_eq("drain_len",    cyc - issue_cyc[1], 11);
      check_eq("drain_issues", issue_cnt, 2);
      check_eq("drain_dat",    o_dat, 6);
      start_job(0, 1, t0);
      wait_val(200, at);
      check_eq("post_abort_lat",  at - t0, 12);
      check_eq("post_abort_dat",  o_dat, 1);
      check_eq("post_abort_iter", o_iter_cnt, 1);
      consume();

      // reset mid-WAIT, late result must be ignored
      issue_cnt = 0;
      start_job(3, 5, t0);
      repeat (4) tick();
      i_rst = 1'b1;
      #1;
      check_reset_outs("midrst");
      tick();
      i_rst = 1'b0;
      repeat (8) tick();
      check_eq("late_busy", o_busy, 0);
      check_eq("late_val",  o_val, 0);
      check_eq("late_dat",  o_dat, 0);
      check_eq("late_iter", o_iter_cnt, 0);
      start_job(7, 2, t0);
      wait_val(200, at);
      check_eq("post_rst_lat",  at - t0, 23);
      check_eq("post_rst_dat",  o_dat, 9);
      check_eq("post_rst_iter", o_iter_cnt, 2);
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vdf_sq_sequencer.md
# vdf_sq_sequencer

Iteration controller for the pipelined modular squarer in the VDF evaluation path. Accepts a start value and an iteration count T, issues the value to the squarer, captures each result and feeds it back until T squarings are done, then holds the final value until it is consumed. Tolerates any squarer latency by waiting on its valid, times out a missing result, and drains in-flight work on abort, so stale results never reach a later job.

## Interface
- WORD_BITS, 8, bits per polynomial coefficient word
- NUM_WORDS, 4, words in the modulus
- REDUN_WORD_BITS, 1, redundant carry bits per coefficient
- I_WORD, NUM_WORDS+1, coefficients per value
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, bits per coefficient
- ITER_BITS, 32, width of iteration count
- TIMEOUT, 1024, maximum cycles allowed between issue and result (≥2)

- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset; one clock, asynchronous and active-high
- i_start  in  1  job request; sampled only in IDLE
- i_iters  in  ITER_BITS  squarings to perform
- i_dat  in  I_WORD×COEF_BITS  initial value
- i_abort  in  1  cancel current job
- o_busy  out  1  high in every state except IDLE
- o_sq_val  out  1  one-cycle issue strobe to squarer
- o_sq_dat  out  I_WORD×COEF_BITS  squarer operand
- i_sq_val  in  1  squarer result valid
- i_sq_dat  in  I_WORD×COEF_BITS  squarer result
- o_val  out  1  final result valid (DONE)
- o_dat  out  I_WORD×COEF_BITS  final result
- i_rdy  in  1  consumer accepts o_dat
- o_err  out  1  job ended by timeout; valid with o_val
- o_iter_cnt  out  ITER_BITS  squarings completed in current/last job

## Operation
- States: IDLE, WAIT, DONE, DRAIN. All outputs registered.
- IDLE: on i_start, latch i_dat into value register, remaining ← i_iters, o_iter_cnt ← 0, o_err ← 0. If i_iters = 0 go to DONE, value unchanged; else go to WAIT and assert o_sq_val for one cycle with o_sq_dat = i_dat.
- WAIT: timeout counter counts cycles since the last o_sq_val. On i_sq_val: value ← i_sq_dat, o_iter_cnt += 1, remaining -= 1; if remaining becomes 0 go to DONE, else stay in WAIT and assert o_sq_val the next cycle with o_sq_dat = i_sq_dat, counter cleared.
- Timeout: counter reaches TIMEOUT-1 with no i_sq_val → DONE with o_err = 1, o_dat = last captured value.
- DONE: o_val = 1, o_dat held stable; on i_rdy go to IDLE and drop o_val the next cycle.
- Abort: i_abort in WAIT → DRAIN. In DRAIN, no issue; the next i_sq_val, or timeout, is discarded and returns the block to IDLE. i_abort in DONE → IDLE, result dropped. Ignored in IDLE/DRAIN.
- i_sq_val in IDLE or DONE: ignored, no state change.
- At most one squarer operation in flight at any time.
- Simultaneous i_sq_val and i_abort in WAIT: abort wins; result discarded; go straight to IDLE, since nothing remains in flight.
- Simultaneous timeout and i_sq_val: result wins.
- o_iter_cnt wraps naturally. i_iters = 2^ITER_BITS−1 is legal.

## Timing
- Reset: state IDLE; o_busy, o_sq_val, o_val, o_err = 0; o_dat, o_sq_dat, o_iter_cnt = 0; counters cleared. Reset mid-job abandons it; a squarer result arriving after reset is ignored in IDLE.
- Start sampled at edge 0 → o_busy and o_sq_val high in cycle 1.
- Squarer latency L, counted from the o_sq_val cycle to the i_sq_val cycle → next o_sq_val L+1 cycles after the previous one. Iteration period L+1.
- Final capture at edge n → o_val high from cycle n+1. Total latency from start to o_val is 1 + T·(L+1) cycles. For T = 0, o_val is high in cycle 1.
- o_val/i_rdy: transfer occurs in a cycle with both high. o_val is low the following cycle. A new i_start is accepted no earlier than the cycle after the return to IDLE.

## Test plan
- Reset, then T=0 start with i_dat=0x1234: o_val in cycle 1, o_dat=0x1234, o_iter_cnt=0, no o_sq_val pulse.
- Model squarer as +1 with L=10. Start with value 5, T=4. Require: exactly 4 o_sq_val pulses spaced 11 cycles apart; o_dat=9; o_iter_cnt=4; o_err=0; o_val in cycle 45. Hold i_rdy low 5 cycles and check o_dat stays stable.
- Model squarer drops the 2nd result, TIMEOUT=16, T=3: o_val with o_err=1, o_iter_cnt=1, o_dat=6.
- Abort 3 cycles after 2nd issue, L=10: DRAIN until result, no o_val, o_busy low after result. An immediate new job with value 0, T=1 gives o_dat=1, with the stale result not used.
- Spurious i_sq_val in IDLE and DONE: no state, o_dat or o_iter_cnt change.
- Assert i_rst mid-WAIT: all outputs return to their reset values at once. A late i_sq_val is ignored. The next job (value 7, T=2) gives 9.
